// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle integer divider.
// Holds the FSM state enum, the iteration count and the counter width.
package div_pkg;

    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Ports: rem_i/quo_i/div_i = current partial remainder, quotient shift
// register and divisor; rem_o/quo_o = values after shift + trial subtract.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // The extra top bit keeps the shifted remainder exact; since the
    // remainder stays below the divisor, diff[WIDTH] is a clean sign bit.
    assign rem_sh = {rem_i, quo_i[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, div_i};

    always_comb begin
        rem_o = rem_sh[WIDTH-1:0];
        quo_o = {quo_i[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_o = diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU for the execute stage; stalls E while running.
// Ports: clk, rst (async, active-high), start_i, signed_i, a_i, b_i,
// annul_i (exception flush from M), stall_o (div_stallE), ready_o
// (one-cycle done pulse), result_o = {remainder, quotient}.
// Optional macro DIV_ZERO_FAST_EN: zero divisor completes in one cycle
// with result {dividend, all ones} and no sign fix.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               annul_i,
    output logic               stall_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int CW = (WIDTH > DIV_CYCLES) ? $clog2(WIDTH) : CNT_W;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_e state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [2*WIDTH-1:0] res_q, res_d;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] fix_rem;
    logic [WIDTH-1:0] fix_quo;

    // Magnitudes for DIV; the most negative value maps onto itself,
    // which is still the correct unsigned magnitude.
    assign a_abs = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_abs = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Sign fix is applied on the final step so result_o is already
    // valid in the DONE cycle.
    assign fix_rem = rneg_q ? -step_rem : step_rem;
    assign fix_quo = qneg_q ? -step_quo : step_quo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;

        unique case (state_q)
            IDLE: begin
                if (start_i && !annul_i) begin
                    rem_d   = '0;
                    quo_d   = a_abs;
                    dvs_d   = b_abs;
                    qneg_d  = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    rneg_d  = signed_i & a_i[WIDTH-1];
                    cnt_d   = '0;
                    state_d = BUSY;
`ifdef DIV_ZERO_FAST_EN
                    if (b_i == '0) begin
                        state_d = DONE;
                        res_d   = {a_i, {WIDTH{1'b1}}};
                    end
`endif
                end
            end
            BUSY: begin
                // Flush or the instruction leaving E abandons the divide.
                if (annul_i || !start_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        res_d   = {fix_rem, fix_quo};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stall_o  = start_i & (state_q != DONE) & ~annul_i;
    assign ready_o  = (state_q == DONE);
    assign result_o = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
// Vectors carry hand-computed results, latencies and stall counts.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        annul_i;
    logic        stall_o;
    logic        ready_o;
    logic [63:0] result_o;

    int n_chk;
    int n_fail;
    int cyc;
    int rdy_cyc;

    div_unit #(
        .WIDTH (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .signed_i (signed_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .annul_i  (annul_i),
        .stall_o  (stall_o),
        .ready_o  (ready_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start a divide on the next cycle and follow it to its ready pulse.
    task automatic do_div(input string tag, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat,
                          input logic adone);
        int n;
        int st;
        n  = 0;
        st = 0;
        @(posedge clk);
        #1;
        annul_i  = 1'b0;
        start_i  = 1'b1;
        signed_i = s;
        a_i      = a;
        b_i      = b;
        while (n < 100) begin
            @(negedge clk);
            if (ready_o) break;
            if (stall_o) st++;
            n++;
        end
        rdy_cyc = cyc;
        check($sformatf("%s_lat", tag), 64'(n), 64'(lat));
        check($sformatf("%s_stallcnt", tag), 64'(st), 64'(lat));
        check($sformatf("%s_stall_done", tag), 64'(stall_o), 64'd0);
        check($sformatf("%s_res", tag), result_o, exp);
        if (adone) begin
            annul_i = 1'b1;
            #1;
            check($sformatf("%s_annul_rdy", tag), 64'(ready_o), 64'd1);
            check($sformatf("%s_annul_res", tag), result_o, exp);
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        start_i = 1'b0;
        annul_i = 1'b0;
    endtask

    task automatic no_ready(input string tag, input int ncyc,
                            input logic [63:0] hold);
        int seen;
        seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        check($sformatf("%s_noready", tag), 64'(seen), 64'd0);
        check($sformatf("%s_hold", tag), result_o, hold);
    endtask

    int zlat;
    int r1;
    logic [63:0] sz_exp;

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rdy_cyc  = 0;
        rst      = 1'b1;
        start_i  = 1'b0;
        signed_i = 1'b0;
        a_i      = '0;
        b_i      = '0;
        annul_i  = 1'b0;
`ifdef DIV_ZERO_FAST_EN
        zlat   = 1;
        sz_exp = {32'hFFFF_FFFB, 32'hFFFF_FFFF};
`else
        zlat   = 33;
        sz_exp = {32'hFFFF_FFFB, 32'h0000_0001};
`endif

        #12;
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_stall0", 64'(stall_o), 64'd0);
        start_i = 1'b1;
        #1;
        check("rst_stall1", 64'(stall_o), 64'd1);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0);
        go_idle();
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
               {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b0);
        go_idle();
        do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
               {32'd0, 32'h8000_0000}, 33, 1'b0);
        go_idle();
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
               {32'd1, 32'hFFFF_FFFD}, 33, 1'b0);
        go_idle();
        do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1,
               {32'd0, 32'hFFFF_FFFF}, 33, 1'b0);
        go_idle();

        do_div("b2b_20_3", 1'b0, 32'd20, 32'd3, {32'd2, 32'd6}, 33, 1'b0);
        r1 = rdy_cyc;
        do_div("b2b_9_4", 1'b0, 32'd9, 32'd4, {32'd1, 32'd2}, 33, 1'b0);
        check("b2b_gap", 64'(rdy_cyc - r1), 64'd34);
        go_idle();

        // Flush in BUSY cycle 10.
        @(posedge clk);
        #1;
        start_i  = 1'b1;
        signed_i = 1'b0;
        a_i      = 32'd50;
        b_i      = 32'd7;
        for (int i = 0; i < 10; i++) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(negedge clk);
        check("annul_stall", 64'(stall_o), 64'd0);
        go_idle();
        no_ready("annul", 40, {32'd1, 32'd2});
        do_div("after_annul", 1'b0, 32'd50, 32'd7, {32'd1, 32'd7}, 33, 1'b0);
        go_idle();

        // Start and flush together in IDLE.
        @(posedge clk);
        #1;
        start_i = 1'b1;
        annul_i = 1'b1;
        a_i     = 32'd8;
        b_i     = 32'd2;
        @(negedge clk);
        check("idle_annul_stall", 64'(stall_o), 64'd0);
        go_idle();
        no_ready("idle_annul", 40, {32'd1, 32'd7});

        // Start dropped mid-BUSY abandons the divide.
        @(posedge clk);
        #1;
        start_i = 1'b1;
        for (int i = 0; i < 5; i++) @(posedge clk);
        go_idle();
        no_ready("start_drop", 40, {32'd1, 32'd7});

        // Flush in the DONE cycle keeps the pulse and the result.
        do_div("annul_done", 1'b0, 32'd30, 32'd4, {32'd2, 32'd7}, 33, 1'b1);
        go_idle();

        do_div("divu_5_0", 1'b0, 32'd5, 32'd0,
               {32'd5, 32'hFFFF_FFFF}, zlat, 1'b0);
        go_idle();
        do_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, sz_exp, zlat, 1'b0);
        go_idle();

        // Asynchronous reset in the middle of BUSY.
        @(posedge clk);
        #1;
        start_i  = 1'b1;
        signed_i = 1'b0;
        a_i      = 32'd77;
        b_i      = 32'd5;
        for (int i = 0; i < 6; i++) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_ready", 64'(ready_o), 64'd0);
        check("arst_result", result_o, 64'd0);
        check("arst_stall_hi", 64'(stall_o), 64'd1);
        start_i = 1'b0;
        #1;
        check("arst_stall_lo", 64'(stall_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        no_ready("arst", 40, 64'd0);

        do_div("post_rst", 1'b0, 32'd77, 32'd5, {32'd2, 32'd15}, 33, 1'b0);
        go_idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
